mem_port_arbiter: RTL and testbench

- Shares the single DPI-backed data memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Sequences exactly one memory strobe per transaction, then models a programmable access latency before returning data.
- Sits between IFU/LSU and the memory module; it drives that module's read/write address, data, mask and enable inputs.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU (read/write): one strobe per transaction, then a programmable response latency.
// Define MEM_PORT_ARB_RR_EN for round-robin grant; otherwise the LSU wins whenever both requesters are valid.
//   state  | meaning
//   IDLE   | waiting for a request; ready goes to the grant winner
//   ACCESS | single memory strobe; read data is captured at the end of this cycle
//   WAIT   | counting down the extra access latency
//   RESP   | response presented to the owner until it is consumed
module mem_port_arbiter #(
    parameter int LATENCY = 1,
    parameter int LAT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_rdata,
    output logic [63:0] mem_raddr,
    output logic        mem_ren,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    state_t             state, state_nxt;
    logic [LAT_W-1:0]   cnt_q, cnt_nxt;
    logic               owner_lsu_q;
    logic [63:0]        addr_q;
    logic               wen_q;
    logic [63:0]        wdata_q;
    logic [7:0]         wmask_q;
    logic [63:0]        rdata_q;
    logic               grant_lsu;
    logic               handshake;

`ifdef MEM_PORT_ARB_RR_EN
    // last_grant_q: 1 = LSU won the previous handshake
    logic last_grant_q;

    always_comb begin
        if (ifu_req_valid && lsu_req_valid)
            grant_lsu = ~last_grant_q;
        else
            grant_lsu = lsu_req_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_q <= 1'b0;
        else if (handshake)
            last_grant_q <= grant_lsu;
    end
`else
    assign grant_lsu = lsu_req_valid;
`endif

    assign handshake = (state == IDLE) && (ifu_req_valid || lsu_req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        mem_raddr      = '0;
        mem_ren        = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        mem_wen        = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                ifu_req_ready = ifu_req_valid && !grant_lsu;
                lsu_req_ready = lsu_req_valid && grant_lsu;
                if (handshake)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                if (wen_q) begin
                    mem_wen   = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = wdata_q;
                    mem_wmask = wmask_q;
                end else begin
                    mem_ren   = 1'b1;
                    mem_raddr = addr_q;
                end
                if (LATENCY > 0) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_LOAD;
                end else begin
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == '0)
                    state_nxt = RESP;
                else
                    cnt_nxt = cnt_q - 1'b1;
            end
            RESP: begin
                if (owner_lsu_q) begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = rdata_q;
                    if (lsu_resp_ready)
                        state_nxt = IDLE;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_rdata      = rdata_q;
                    if (ifu_resp_ready)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are captured at the handshake so requesters may change their inputs afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
        end else begin
            if (handshake) begin
                owner_lsu_q <= grant_lsu;
                if (grant_lsu) begin
                    addr_q  <= lsu_addr;
                    wen_q   <= lsu_wen;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end else begin
                    addr_q  <= ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (state == ACCESS)
                rdata_q <= wen_q ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=1 main instance plus LATENCY=0 and LATENCY=3 instances for response timing.
// Expected grant order follows MEM_PORT_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

    localparam logic [63:0] IFU_WORD = 64'h0000_0013_0000_0097;
    localparam logic [63:0] NO_READ  = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        ifu_req_valid = 1'b0, ifu_resp_ready = 1'b0;
    logic [63:0] ifu_addr = '0;
    logic        lsu_req_valid = 1'b0, lsu_wen = 1'b0, lsu_resp_ready = 1'b0;
    logic [63:0] lsu_addr = '0, lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    wire         ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
    wire  [63:0] ifu_rdata, lsu_rdata, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    wire  [7:0]  mem_wmask;
    wire         mem_ren, mem_wen, busy;

    logic        lt_valid = 1'b0;
    logic [63:0] lt_addr = '0;
    wire         l0_ifu_req_ready, l0_ifu_resp_valid, l0_lsu_req_ready, l0_lsu_resp_valid;
    wire  [63:0] l0_ifu_rdata, l0_lsu_rdata, l0_mem_raddr, l0_mem_waddr, l0_mem_wdata, l0_mem_rdata;
    wire  [7:0]  l0_mem_wmask;
    wire         l0_mem_ren, l0_mem_wen, l0_busy;
    wire         l3_ifu_req_ready, l3_ifu_resp_valid, l3_lsu_req_ready, l3_lsu_resp_valid;
    wire  [63:0] l3_ifu_rdata, l3_lsu_rdata, l3_mem_raddr, l3_mem_waddr, l3_mem_wdata, l3_mem_rdata;
    wire  [7:0]  l3_mem_wmask;
    wire         l3_mem_ren, l3_mem_wen, l3_busy;

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h8000_0000)
            return IFU_WORD;
        return {~a[31:0], a[31:0]};
    endfunction

    assign mem_rdata    = mem_ren    ? mem_fn(mem_raddr)    : NO_READ;
    assign l0_mem_rdata = l0_mem_ren ? mem_fn(l0_mem_raddr) : NO_READ;
    assign l3_mem_rdata = l3_mem_ren ? mem_fn(l3_mem_raddr) : NO_READ;

    mem_port_arbiter #(.LATENCY(1), .LAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wen(mem_wen),
        .busy(busy)
    );

    mem_port_arbiter #(.LATENCY(0), .LAT_W(4)) dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(lt_valid), .ifu_req_ready(l0_ifu_req_ready), .ifu_addr(lt_addr),
        .ifu_resp_valid(l0_ifu_resp_valid), .ifu_resp_ready(1'b1), .ifu_rdata(l0_ifu_rdata),
        .lsu_req_valid(1'b0), .lsu_req_ready(l0_lsu_req_ready), .lsu_addr(64'h0),
        .lsu_wen(1'b0), .lsu_wdata(64'h0), .lsu_wmask(8'h0),
        .lsu_resp_valid(l0_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(l0_lsu_rdata),
        .mem_raddr(l0_mem_raddr), .mem_ren(l0_mem_ren), .mem_rdata(l0_mem_rdata),
        .mem_waddr(l0_mem_waddr), .mem_wdata(l0_mem_wdata), .mem_wmask(l0_mem_wmask), .mem_wen(l0_mem_wen),
        .busy(l0_busy)
    );

    mem_port_arbiter #(.LATENCY(3), .LAT_W(4)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(lt_valid), .ifu_req_ready(l3_ifu_req_ready), .ifu_addr(lt_addr),
        .ifu_resp_valid(l3_ifu_resp_valid), .ifu_resp_ready(1'b1), .ifu_rdata(l3_ifu_rdata),
        .lsu_req_valid(1'b0), .lsu_req_ready(l3_lsu_req_ready), .lsu_addr(64'h0),
        .lsu_wen(1'b0), .lsu_wdata(64'h0), .lsu_wmask(8'h0),
        .lsu_resp_valid(l3_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(l3_lsu_rdata),
        .mem_raddr(l3_mem_raddr), .mem_ren(l3_mem_ren), .mem_rdata(l3_mem_rdata),
        .mem_waddr(l3_mem_waddr), .mem_wdata(l3_mem_wdata), .mem_wmask(l3_mem_wmask), .mem_wen(l3_mem_wen),
        .busy(l3_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the requests already driven; leaves the DUT idle at negedge+1.
    task automatic arb_round(input logic exp_lsu, input string tag);
        logic [63:0] exp_data;
        exp_data = exp_lsu ? mem_fn(lsu_addr) : mem_fn(ifu_addr);
        #1;
        chk({tag, "_lsu_ready"}, lsu_req_ready, exp_lsu);
        chk({tag, "_ifu_ready"}, ifu_req_ready, !exp_lsu);
        @(negedge clk);
        if (exp_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        #1;
        chk({tag, "_strobe"}, mem_ren, 1'b1);
        chk({tag, "_loser_ready"}, exp_lsu ? ifu_req_ready : lsu_req_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if (exp_lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
        #1;
        chk({tag, "_resp_valid"}, exp_lsu ? lsu_resp_valid : ifu_resp_valid, 1'b1);
        chk({tag, "_other_resp"}, exp_lsu ? ifu_resp_valid : lsu_resp_valid, 1'b0);
        chk({tag, "_rdata"}, exp_lsu ? lsu_rdata : ifu_rdata, exp_data);
        @(negedge clk);
        lsu_resp_ready = 1'b0;
        ifu_resp_ready = 1'b0;
        #1;
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [2:0]  exp_win;
        logic [63:0] hold_data;
        int          first0, first3;
        logic [63:0] data3;

`ifdef MEM_PORT_ARB_RR_EN
        exp_win = 3'b101;
`else
        exp_win = 3'b111;
`endif
        // reset state
        @(negedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_mem_wmask", mem_wmask, 8'h00);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // IFU read with response backpressure
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr = 64'h8000_0000;
        #1;
        chk("ifu_ready", ifu_req_ready, 1'b1);
        chk("ifu_lsu_ready", lsu_req_ready, 1'b0);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        ifu_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("ifu_strobe_ren", mem_ren, 1'b1);
        chk("ifu_strobe_raddr", mem_raddr, 64'h8000_0000);
        chk("ifu_strobe_wen", mem_wen, 1'b0);
        chk("ifu_strobe_busy", busy, 1'b1);
        @(negedge clk); #1;
        chk("ifu_wait_ren", mem_ren, 1'b0);
        chk("ifu_wait_resp", ifu_resp_valid, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            lsu_req_valid = 1'b1;
            #1;
            chk("bp_resp_valid", ifu_resp_valid, 1'b1);
            chk("bp_rdata", ifu_rdata, IFU_WORD);
            chk("bp_busy", busy, 1'b1);
            chk("bp_lsu_ready", lsu_req_ready, 1'b0);
            @(negedge clk);
        end
        lsu_req_valid = 1'b0;
        ifu_resp_ready = 1'b1;
        #1;
        chk("bp_release_valid", ifu_resp_valid, 1'b1);
        @(negedge clk);
        ifu_resp_ready = 1'b0;
        #1;
        chk("bp_done_valid", ifu_resp_valid, 1'b0);
        chk("bp_done_busy", busy, 1'b0);

        // LSU store
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_wen = 1'b1;
        lsu_addr = 64'h8000_0100;
        lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        lsu_wmask = 8'h0F;
        #1;
        chk("st_ready", lsu_req_ready, 1'b1);
        chk("st_idle_wmask", mem_wmask, 8'h00);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        lsu_addr = 64'h0;
        lsu_wdata = 64'h0;
        lsu_wmask = 8'hFF;
        #1;
        chk("st_wen", mem_wen, 1'b1);
        chk("st_waddr", mem_waddr, 64'h8000_0100);
        chk("st_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("st_wmask", mem_wmask, 8'h0F);
        chk("st_ren", mem_ren, 1'b0);
        @(negedge clk); #1;
        chk("st_wait_wen", mem_wen, 1'b0);
        chk("st_wait_wmask", mem_wmask, 8'h00);
        chk("st_wait_resp", lsu_resp_valid, 1'b0);
        @(negedge clk);
        lsu_resp_ready = 1'b1;
        #1;
        chk("st_resp_valid", lsu_resp_valid, 1'b1);
        chk("st_resp_rdata", lsu_rdata, 64'h0);
        chk("st_resp_wmask", mem_wmask, 8'h00);
        chk("st_ifu_resp", ifu_resp_valid, 1'b0);
        @(negedge clk);
        lsu_resp_ready = 1'b0;
        lsu_wen = 1'b0;
        lsu_wmask = 8'h00;
        #1;
        chk("st_done_busy", busy, 1'b0);

        // arbitration from a fresh reset (last grant = IFU)
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lsu_addr = 64'h8000_0200;
        ifu_addr = 64'h8000_0300;
        lsu_req_valid = 1'b1;
        ifu_req_valid = 1'b1;
        arb_round(exp_win[2], "arb1");
        if (exp_win[2]) lsu_req_valid = 1'b1; else ifu_req_valid = 1'b1;
        arb_round(exp_win[1], "arb2");
        if (exp_win[1]) lsu_req_valid = 1'b1; else ifu_req_valid = 1'b1;
        arb_round(exp_win[0], "arb3");
        arb_round(1'b0, "arb_ifu_after");

        // LATENCY=0 and LATENCY=3 response timing
        @(negedge clk);
        lt_valid = 1'b1;
        lt_addr = 64'h8000_0400;
        #1;
        chk("lat_ready", {l0_ifu_req_ready, l3_ifu_req_ready}, 2'b11);
        first0 = -1;
        first3 = -1;
        data3 = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            lt_valid = 1'b0;
            lt_addr = 64'h0;
            #1;
            if (l0_ifu_resp_valid && first0 < 0) first0 = k;
            if (l3_ifu_resp_valid && first3 < 0) begin
                first3 = k;
                data3 = l3_ifu_rdata;
            end
        end
        chk("lat0_cycle", 64'(first0), 64'd2);
        chk("lat3_cycle", 64'(first3), 64'd5);
        chk("lat3_rdata", data3, mem_fn(64'h8000_0400));

        // asynchronous reset during WAIT
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr = 64'h8000_0000;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        #1;
        hold_data = {63'h0, busy};
        chk("pre_rst_busy", hold_data, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_ren", mem_ren, 1'b0);
        chk("arst_resp", ifu_resp_valid, 1'b0);
        chk("arst_rdata", ifu_rdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ifu_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("post_rst_resp", ifu_resp_valid, 1'b0);
            chk("post_rst_strobe", {mem_ren, mem_wen}, 2'b00);
            chk("post_rst_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
